// File: rtl/wb_pkg.sv
// Shared widths, buffer entry type and back-bus pack/unpack helpers for the
// write-back port arbiter.
package wb_pkg;

  localparam int unsigned RW_W   = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BACK_W = 38;

  typedef struct packed {
    logic              live;
    logic [RW_W-1:0]   rw;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Field order matches the bus layout {we, data, rw}.
  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] data;
    logic [RW_W-1:0]   rw;
  } wb_back_t;

  function automatic logic [BACK_W-1:0] pack_back(input logic              we,
                                                  input logic [DATA_W-1:0] data,
                                                  input logic [RW_W-1:0]   rw);
    return {we, data, rw};
  endfunction

  function automatic wb_back_t unpack_back(input logic [BACK_W-1:0] bus);
    return wb_back_t'(bus);
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Requester (e.g. multiply/divide unit) result handshake into the write-back
// port arbiter.
interface wb_port_arbiter_if;
  import wb_pkg::*;

  logic              md_valid;
  logic [RW_W-1:0]   md_rw;
  logic [DATA_W-1:0] md_data;
  logic              md_ready;

  modport master (output md_valid, output md_rw, output md_data, input md_ready);
  modport slave  (input md_valid, input md_rw, input md_data, output md_ready);

endinterface

// File: rtl/wb_kill_fifo.sv
// Small FIFO of requester results with per-entry live bits, kill-by-register,
// register-match queries and head peek/pop.
module wb_kill_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [RW_W-1:0]   push_rw_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              kill_i,
  input  logic [RW_W-1:0]   kill_rw_i,
  input  logic [RW_W-1:0]   q_rs_i,
  input  logic [RW_W-1:0]   q_rt_i,
  output logic              full_o,
  output logic              empty_o,
  output wb_entry_t         head_o,
  output logic              match_rs_o,
  output logic              match_rt_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]            rd_q, rd_d, wr_q, wr_d;
  wb_entry_t [DEPTH-1:0]  mem_q, mem_d;

  assign empty_o = (rd_q == wr_q);
  assign full_o  = (rd_q[AW] != wr_q[AW]) && (rd_q[AW-1:0] == wr_q[AW-1:0]);
  assign head_o  = mem_q[rd_q[AW-1:0]];

  // Kills act on older entries first; the entry written this cycle survives.
  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if ((kill_i && (mem_q[i].rw == kill_rw_i)) ||
          (push_i && (push_rw_i != '0) && (mem_q[i].rw == push_rw_i))) begin
        mem_d[i].live = 1'b0;
      end
    end
    if (pop_i) begin
      mem_d[rd_q[AW-1:0]].live = 1'b0;
      rd_d = rd_q + 1'b1;
    end
    if (push_i) begin
      mem_d[wr_q[AW-1:0]].live = (push_rw_i != '0);
      mem_d[wr_q[AW-1:0]].rw   = push_rw_i;
      mem_d[wr_q[AW-1:0]].data = push_data_i;
      wr_d = wr_q + 1'b1;
    end
  end

  // Slots outside the occupied window always have live cleared.
  always_comb begin
    match_rs_o = 1'b0;
    match_rt_o = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (mem_q[i].live && (mem_q[i].rw == q_rs_i)) match_rs_o = 1'b1;
      if (mem_q[i].live && (mem_q[i].rw == q_rt_i)) match_rt_o = 1'b1;
    end
    match_rs_o = match_rs_o && (q_rs_i != '0);
    match_rt_o = match_rt_o && (q_rt_i != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      mem_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the pipeline WB bus (always wins)
// and a buffered long-latency requester. WB_ARB_BYPASS_EN enables a same-cycle
// requester path when the buffer is empty and the port is free.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BACK_W-1:0]   i_WB_BACK,
  wb_port_arbiter_if.slave    md,
  input  logic [RW_W-1:0]     q_rs,
  input  logic [RW_W-1:0]     q_rt,
  output logic                o_pend_rs,
  output logic                o_pend_rt,
  output logic                o_wb_stall,
  output logic [BACK_W-1:0]   o_RF_BACK
);

  localparam int unsigned       CntW   = $clog2(MAX_WAIT + 1);
  localparam logic [CntW-1:0]   MaxCnt = CntW'(MAX_WAIT);

  wb_back_t   wb;
  wb_entry_t  head;
  logic       full, empty;
  logic       pipe_grant, head_live, buf_grant, byp, push, pop;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic       stall_q, stall_d;

  assign wb         = unpack_back(i_WB_BACK);
  assign pipe_grant = wb.we && (wb.rw != '0);
  assign head_live  = !empty && head.live;
  assign buf_grant  = !pipe_grant && head_live;
  // A dead head leaves without touching the port, whoever owns it.
  assign pop        = !empty && (!head.live || buf_grant);

`ifdef WB_ARB_BYPASS_EN
  assign byp = empty && !pipe_grant && md.md_valid && (md.md_rw != '0);
`else
  assign byp = 1'b0;
`endif

  assign md.md_ready = !full;
  assign push        = md.md_valid && !full && !byp;
  assign o_wb_stall  = stall_q;

  wb_kill_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_rw_i   (md.md_rw),
    .push_data_i (md.md_data),
    .pop_i       (pop),
    .kill_i      (pipe_grant),
    .kill_rw_i   (wb.rw),
    .q_rs_i      (q_rs),
    .q_rt_i      (q_rt),
    .full_o      (full),
    .empty_o     (empty),
    .head_o      (head),
    .match_rs_o  (o_pend_rs),
    .match_rt_o  (o_pend_rt)
  );

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (pop || empty) begin
      wait_cnt_d = '0;
    end else if (head_live && pipe_grant && (wait_cnt_q != MaxCnt)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
    stall_d = (wait_cnt_q == MaxCnt) && !pop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q <= '0;
      stall_q    <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      stall_q    <= stall_d;
    end
  end

  // In reset the register file is held too, so the WB bus passes straight through.
  always_comb begin
    o_RF_BACK = '0;
    if (!rst || pipe_grant) begin
      o_RF_BACK = pack_back(wb.we, wb.data, wb.rw);
    end else if (buf_grant) begin
      o_RF_BACK = pack_back(1'b1, head.data, head.rw);
    end else if (byp) begin
      o_RF_BACK = pack_back(1'b1, md.md_data, md.md_rw);
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_wb_port_arbiter;
  import wb_pkg::*;

  localparam int unsigned DEPTH    = 2;
  localparam int unsigned MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [37:0] wb_back;
  logic [4:0]  q_rs, q_rt;
  logic        pend_rs, pend_rt, stall;
  logic [37:0] rf_back;

  int compared   = 0;
  int mismatched = 0;

  wb_port_arbiter_if md_if ();

  wb_port_arbiter #(
    .DEPTH    (DEPTH),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_WB_BACK  (wb_back),
    .md         (md_if.slave),
    .q_rs       (q_rs),
    .q_rt       (q_rt),
    .o_pend_rs  (pend_rs),
    .o_pend_rt  (pend_rt),
    .o_wb_stall (stall),
    .o_RF_BACK  (rf_back)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        live;
    logic [4:0]  rw;
    logic [31:0] data;
  } ent_t;

  ent_t mq[$];
  int   m_wait;
  logic m_stall;

  task automatic drive(input logic we, input logic [4:0] wrw, input logic [31:0] wdata,
                       input logic mv, input logic [4:0] mrw, input logic [31:0] mdata);
    wb_back         = {we, wdata, wrw};
    md_if.md_valid  = mv;
    md_if.md_rw     = mrw;
    md_if.md_data   = mdata;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    q_rs = 5'd6;
    q_rt = 5'd7;
    @(negedge clk);
    #1;
    compared++;
    if (md_if.md_ready !== 1'b1 || stall !== 1'b0 || pend_rs !== 1'b0 || rf_back !== 38'd0) begin
      mismatched++;
      $display("FAIL reset_state: got ready=%b stall=%b pend=%b rf=%h want 1 0 0 0",
               md_if.md_ready, stall, pend_rs, rf_back);
    end
    drive(1'b1, 5'd3, 32'hdead, 1'b0, 5'd0, 32'd0);
    #1;
    compared++;
    if (rf_back !== {1'b1, 32'hdead, 5'd3}) begin
      mismatched++;
      $display("FAIL reset_passthru: got %h want %h", rf_back, {1'b1, 32'hdead, 5'd3});
    end
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 5'd3, 32'h1, 1'b1, 5'd6, 32'h66);
    @(negedge clk);
    drive(1'b1, 5'd3, 32'h2, 1'b1, 5'd7, 32'h77);
    @(negedge clk);
    drive(1'b1, 5'd3, 32'h3, 1'b0, 5'd0, 32'd0);
    #1;
    compared++;
    if (md_if.md_ready !== 1'b0 || pend_rs !== 1'b1 || pend_rt !== 1'b1) begin
      mismatched++;
      $display("FAIL prefill_full: got ready=%b pend=%b%b want 0 11",
               md_if.md_ready, pend_rs, pend_rt);
    end
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    compared++;
    if (md_if.md_ready !== 1'b1 || stall !== 1'b0 || pend_rs !== 1'b0 || pend_rt !== 1'b0 ||
        rf_back !== 38'd0) begin
      mismatched++;
      $display("FAIL midreset: got ready=%b stall=%b pend=%b%b rf=%h want 1 0 00 0",
               md_if.md_ready, stall, pend_rs, pend_rt, rf_back);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    compared++;
    if (pend_rs !== 1'b0 || pend_rt !== 1'b0 || rf_back !== 38'd0) begin
      mismatched++;
      $display("FAIL after_reset_empty: got pend=%b%b rf=%h want 00 0", pend_rs, pend_rt, rf_back);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    q_rs = 5'd5;
    q_rt = 5'd0;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
    #1;
    compared++;
    if (rf_back !== 38'd0 || pend_rs !== 1'b0) begin
      mismatched++;
      $display("FAIL basic_enqueue: got rf=%h pend=%b want 0 0", rf_back, pend_rs);
    end
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    compared++;
    if (rf_back !== {1'b1, 32'h1234, 5'd5} || pend_rs !== 1'b1) begin
      mismatched++;
      $display("FAIL basic_drain: got rf=%h pend=%b want %h 1", rf_back, pend_rs,
               {1'b1, 32'h1234, 5'd5});
    end
    @(negedge clk);
    #1;
    compared++;
    if (rf_back !== 38'd0 || pend_rs !== 1'b0) begin
      mismatched++;
      $display("FAIL basic_after: got rf=%h pend=%b want 0 0", rf_back, pend_rs);
    end
  endtask

  task automatic test_bypass();
    q_rs = 5'd4;
    q_rt = 5'd0;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h55);
    #1;
    compared++;
    if (rf_back !== {1'b1, 32'h55, 5'd4}) begin
      mismatched++;
      $display("FAIL bypass_same_cycle: got %h want %h", rf_back, {1'b1, 32'h55, 5'd4});
    end
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    compared++;
    if (rf_back !== 38'd0 || pend_rs !== 1'b0) begin
      mismatched++;
      $display("FAIL bypass_no_buffer: got rf=%h pend=%b want 0 0", rf_back, pend_rs);
    end
  endtask

  task automatic test_starvation();
    q_rs = 5'd0;
    q_rt = 5'd0;
    drive(1'b1, 5'd3, 32'h30, 1'b1, 5'd7, 32'h70);
    @(negedge clk);
    drive(1'b1, 5'd3, 32'h31, 1'b1, 5'd8, 32'h80);
    @(negedge clk);
    drive(1'b1, 5'd3, 32'h32, 1'b1, 5'd9, 32'h90);
    #1;
    compared++;
    if (md_if.md_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL full_after_two: got ready=%b want 0", md_if.md_ready);
    end
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    compared++;
    if (stall !== 1'b0) begin
      mismatched++;
      $display("FAIL stall_early: got %b want 0", stall);
    end
    @(negedge clk);
    #1;
    compared++;
    if (stall !== 1'b1 || rf_back !== {1'b1, 32'h32, 5'd3}) begin
      mismatched++;
      $display("FAIL stall_raise: got stall=%b rf=%h want 1 %h", stall, rf_back,
               {1'b1, 32'h32, 5'd3});
    end
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h90);
    #1;
    compared++;
    if (rf_back !== {1'b1, 32'h70, 5'd7}) begin
      mismatched++;
      $display("FAIL bubble_drain: got %h want %h", rf_back, {1'b1, 32'h70, 5'd7});
    end
    @(negedge clk);
    #1;
    compared++;
    if (stall !== 1'b0 || md_if.md_ready !== 1'b1 || rf_back !== {1'b1, 32'h80, 5'd8}) begin
      mismatched++;
      $display("FAIL stall_drop: got stall=%b ready=%b rf=%h want 0 1 %h", stall,
               md_if.md_ready, rf_back, {1'b1, 32'h80, 5'd8});
    end
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    compared++;
    if (rf_back !== {1'b1, 32'h90, 5'd9}) begin
      mismatched++;
      $display("FAIL late_push_drain: got %h want %h", rf_back, {1'b1, 32'h90, 5'd9});
    end
    @(negedge clk);
  endtask

  task automatic test_kill();
    q_rs = 5'd9;
    q_rt = 5'd0;
    drive(1'b1, 5'd3, 32'h1, 1'b1, 5'd9, 32'hA);
    @(negedge clk);
    drive(1'b1, 5'd9, 32'hB, 1'b0, 5'd0, 32'd0);
    #1;
    compared++;
    if (rf_back !== {1'b1, 32'hB, 5'd9} || pend_rs !== 1'b1) begin
      mismatched++;
      $display("FAIL kill_pipe_wins: got rf=%h pend=%b want %h 1", rf_back, pend_rs,
               {1'b1, 32'hB, 5'd9});
    end
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    compared++;
    if (rf_back !== 38'd0 || pend_rs !== 1'b0) begin
      mismatched++;
      $display("FAIL kill_dead_head: got rf=%h pend=%b want 0 0", rf_back, pend_rs);
    end
    @(negedge clk);
    #1;
    compared++;
    if (rf_back !== 38'd0) begin
      mismatched++;
      $display("FAIL kill_no_write: got %h want 0", rf_back);
    end
    @(negedge clk);
  endtask

  task automatic test_rw_zero();
    q_rs = 5'd0;
    q_rt = 5'd0;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h99);
    #1;
    compared++;
    if (rf_back[37] !== 1'b0 || md_if.md_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL rw0_accept: got we=%b ready=%b want 0 1", rf_back[37], md_if.md_ready);
    end
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    compared++;
    if (rf_back !== 38'd0) begin
      mismatched++;
      $display("FAIL rw0_no_write: got %h want 0", rf_back);
    end
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'h22);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    compared++;
    if (rf_back !== {1'b1, 32'h22, 5'd2}) begin
      mismatched++;
      $display("FAIL rw0_emptied: got %h want %h", rf_back, {1'b1, 32'h22, 5'd2});
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic        we, mv, pipe, hl, byp, pop, push, full, nstall, e_rs, e_rt;
    logic [4:0]  wrw, mrw;
    logic [31:0] wdata, mdata;
    logic [37:0] e_rf;
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    mq.delete();
    m_wait  = 0;
    m_stall = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      we    = ($urandom_range(0, 9) < 6);
      wrw   = 5'($urandom_range(0, 7));
      wdata = $urandom();
      mv    = ($urandom_range(0, 1) == 1);
      mrw   = 5'($urandom_range(0, 7));
      mdata = $urandom();
      q_rs  = 5'($urandom_range(0, 7));
      q_rt  = 5'($urandom_range(0, 7));
      drive(we, wrw, wdata, mv, mrw, mdata);
      #1;
      full = (mq.size() == DEPTH);
      pipe = we && (wrw != 5'd0);
      hl   = (mq.size() > 0) && mq[0].live;
      byp  = 1'b0;
`ifdef WB_ARB_BYPASS_EN
      byp  = (mq.size() == 0) && !pipe && mv && (mrw != 5'd0);
`endif
      e_rs = 1'b0;
      e_rt = 1'b0;
      foreach (mq[k]) begin
        if (mq[k].live && mq[k].rw == q_rs && q_rs != 5'd0) e_rs = 1'b1;
        if (mq[k].live && mq[k].rw == q_rt && q_rt != 5'd0) e_rt = 1'b1;
      end
      if (pipe)      e_rf = {1'b1, wdata, wrw};
      else if (hl)   e_rf = {1'b1, mq[0].data, mq[0].rw};
      else if (byp)  e_rf = {1'b1, mdata, mrw};
      else           e_rf = 38'd0;
      compared++;
      if (rf_back !== e_rf) begin
        mismatched++;
        $display("FAIL rand_rf cyc %0d: got %h want %h", cyc, rf_back, e_rf);
      end
      compared++;
      if (md_if.md_ready !== !full) begin
        mismatched++;
        $display("FAIL rand_ready cyc %0d: got %b want %b", cyc, md_if.md_ready, !full);
      end
      compared++;
      if (pend_rs !== e_rs || pend_rt !== e_rt) begin
        mismatched++;
        $display("FAIL rand_pend cyc %0d: got %b%b want %b%b", cyc, pend_rs, pend_rt, e_rs, e_rt);
      end
      compared++;
      if (stall !== m_stall) begin
        mismatched++;
        $display("FAIL rand_stall cyc %0d: got %b want %b", cyc, stall, m_stall);
      end
      // Advance the model across the coming rising edge.
      pop    = (mq.size() > 0) && (!mq[0].live || !pipe);
      push   = mv && !full && !byp;
      nstall = (m_wait == MAX_WAIT) && !pop;
      if (pop || mq.size() == 0) m_wait = 0;
      else if (hl && pipe && m_wait < MAX_WAIT) m_wait++;
      m_stall = nstall;
      foreach (mq[k]) begin
        if (pipe && mq[k].rw == wrw) mq[k].live = 1'b0;
        if (push && mrw != 5'd0 && mq[k].rw == mrw) mq[k].live = 1'b0;
      end
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back('{live: (mrw != 5'd0), rw: mrw, data: mdata});
      @(negedge clk);
    end
  endtask

  initial begin
    rst  = 1'b0;
    q_rs = 5'd0;
    q_rt = 5'd0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    test_reset();
`ifdef WB_ARB_BYPASS_EN
    test_bypass();
    @(negedge clk);
`else
    test_basic();
    @(negedge clk);
`endif
    test_starvation();
    test_kill();
    test_rw_zero();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline write-back bus and a long-latency requester, e.g. a multiply/divide unit.
- Pipeline writes always win. Requester results wait in a small buffer and drain on free port cycles.
- Provides a starvation stall, same-register ordering protection, and a pending-register query for hazard logic.
- Sits between the WB stage output and the register-file write inputs.

Parameters:
- DEPTH, 2, buffer entries; power of 2, minimum 2.
- MAX_WAIT, 4, cycles a live buffer head may be denied the port before a stall is raised; minimum 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_WB_BACK  in  38  pipeline write {regWrite, data[31:0], rw[4:0]}.
- md_valid  in  1  requester result valid.
- md_rw  in  5  requester destination register.
- md_data  in  32  requester result.
- md_ready  out  1  buffer can accept; equals !full.
- q_rs  in  5  hazard query register A.
- q_rt  in  5  hazard query register B.
- o_pend_rs  out  1  live buffered entry targets q_rs (q_rs != 0).
- o_pend_rt  out  1  live buffered entry targets q_rt (q_rt != 0).
- o_wb_stall  out  1  request the pipeline to send a WB bubble.
- o_RF_BACK  out  38  register-file write {we, data, rw}; combinational.

Behaviour:
- Reset (rst=0, asynchronous): buffer empty, all live bits 0, wait counter 0, o_wb_stall=0.
  - Combinational outputs while in reset: md_ready=1, o_pend_*=0.
  - o_RF_BACK follows i_WB_BACK in reset. The register file is itself held in reset.
- Pipeline grant: i_WB_BACK.regWrite=1 and rw!=0 → o_RF_BACK = i_WB_BACK.
  - If regWrite=1 and rw==0 → we=0, port is considered free.
- Buffer grant: otherwise, if the head entry is live → o_RF_BACK = {1, head.data, head.rw}; the head pops at the clock edge.
- Idle: otherwise o_RF_BACK = 38'b0.
- Push: md_valid && md_ready at the edge → entry written at the tail, live = (md_rw != 0).
  - An rw=0 push is accepted but never written.
- Kill: on any granted pipeline write to register R, every live entry with rw==R is cleared at that edge, because the older value must not overwrite the newer one.
  - A push to R in that same cycle is not killed.
- Push to R while an older live entry for R exists: the older entry is killed.
- Dead head: pops in any cycle without using the port. At most one pop per cycle.
- Simultaneous push and pop while full: md_ready is 0, so no push. The pop still occurs.
- Pointers are log2(DEPTH) bits plus a wrap bit. full/empty come from pointer compare.
- Wait counter:
  - Increments each cycle a live head is present and the pipeline holds the port.
  - Clears when the head pops or the buffer empties.
  - Saturates at MAX_WAIT.
- o_wb_stall is registered. It is set the cycle after the counter reaches MAX_WAIT and clears the cycle after the head pops.
- Pipeline contract: regWrite=0 on the WB bus the cycle after o_wb_stall rises. If the pipeline violates this, the pipeline still wins; there is no data corruption, only extra delay.
- Latency: requester result to register-file write is at least 1 cycle (enqueue, then drain).
- Reset mid-operation discards all buffered entries. The requester must reissue.

Optional Feature:
- WB_ARB_BYPASS_EN defined: if the buffer is empty, the pipeline is not writing, and md_valid=1 with md_rw!=0, then o_RF_BACK = {1, md_data, md_rw} in the same cycle and no entry is pushed. This gives 0-cycle latency.
- Undefined: every requester result is buffered, with a minimum 1-cycle latency.

Decomposition:
- Package wb_pkg:
  - Constants RW_W=5, DATA_W=32, BACK_W=38.
  - Struct wb_entry_t {live, rw, data}.
  - Functions to pack/unpack the back bus.
- Sub-module wb_kill_fifo: DEPTH-entry FIFO with per-entry live bits, kill-by-register, match outputs for the two query ports, and head peek/pop.
- Arbitration, wait counter and stall logic live in the top module.

Test Plan:
- Reset asserted mid-traffic → next cycle md_ready=1, o_wb_stall=0, o_pend_*=0, buffer empty. With WB idle, o_RF_BACK=0.
- WB idle; md push rw=5, data=0x1234 → next cycle o_RF_BACK={1,0x00001234,5}. o_pend_rs=1 with q_rs=5 during the buffered cycle only.
- Pipeline writes rw=3 every cycle; md pushes rw=7,8,9:
  - md_ready=0 after 2 pushes.
  - o_wb_stall=1 after MAX_WAIT=4 denied cycles.
  - Inject a bubble → rw=7 written, stall drops, rw=9 is accepted.
- Buffer holds rw=9 data 0xA; pipeline writes rw=9 data 0xB → entry killed. The register file sees only 0xB, o_pend for 9 drops, and the dead head pops with no write.
- md push rw=0 → accepted, o_RF_BACK.we never asserted for it, buffer empties.
- With WB_ARB_BYPASS_EN, empty buffer, WB idle, md push rw=4 data=0x55 → same-cycle o_RF_BACK={1,0x55,4}, buffer stays empty.
